// File: rtl/din_cmd_pkg.sv
// Shared Din-bus command definitions: command types, receiver code map and setpoint scaling.
// Used by the transmitter and by receiver-side models.
package din_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_SETFREQ   = 3'd0,
    CMD_RUN       = 3'd1,
    CMD_STOP      = 3'd2,
    CMD_SWEEP_ON  = 3'd3,
    CMD_SWEEP_OFF = 3'd4,
    CMD_PRESET    = 3'd5
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GUARD = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic [2:0] ctype;
    logic [4:0] arg;
  } cmd_t;

  localparam logic [4:0] FREQ_MAX      = 5'd20;
  localparam logic [4:0] CODE_RUN      = 5'd21;
  localparam logic [4:0] CODE_STOP     = 5'd22;
  localparam logic [4:0] CODE_SWEEP_ON = 5'd23;
  localparam logic [4:0] CODE_SWEEPOFF = 5'd24;
  localparam logic [4:0] CODE_PRESET   = 5'd25;
  localparam logic [4:0] CODE_NOP      = 5'd31;

  localparam int SETPOINT_BASE = 12460;
  localparam int SETPOINT_STEP = 224;

  function automatic logic cmd_legal(input logic [2:0] ctype, input logic [4:0] arg);
    logic ok;
    case (ctype)
      CMD_SETFREQ:   ok = (arg <= FREQ_MAX);
      CMD_RUN,
      CMD_STOP,
      CMD_SWEEP_ON,
      CMD_SWEEP_OFF,
      CMD_PRESET:    ok = 1'b1;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [4:0] cmd_encode(input cmd_t c);
    logic [4:0] code;
    case (c.ctype)
      CMD_SETFREQ:   code = c.arg;
      CMD_RUN:       code = CODE_RUN;
      CMD_STOP:      code = CODE_STOP;
      CMD_SWEEP_ON:  code = CODE_SWEEP_ON;
      CMD_SWEEP_OFF: code = CODE_SWEEPOFF;
      CMD_PRESET:    code = CODE_PRESET;
      default:       code = CODE_NOP;
    endcase
    return code;
  endfunction

  function automatic int setpoint(input logic [4:0] idx);
    return SETPOINT_BASE + SETPOINT_STEP * int'(idx);
  endfunction

endpackage

// File: rtl/din_cmd_fifo.sv
// Synchronous show-ahead command FIFO; a push into a full FIFO is honoured when a pop happens
// on the same edge.
module din_cmd_fifo
  import din_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk40MHz,
  input  logic rst_n,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);

  cmd_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == DEPTH_N);
  assign empty     = (count_r == '0);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1'b1);
        2'b01:   count_r <= count_r - (AW + 1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/din_cmd_tx.sv
// Host-side Din command transmitter: validates and buffers commands, frames each code with idle
// codes on the 5-bit bus, and mirrors the receiver state the codes produce.
module din_cmd_tx
  import din_cmd_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 64,
  parameter int unsigned GUARD_CYCLES = 16,
  parameter int unsigned IDLE_CODE    = 31,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned AUTO_PRESET  = 1
) (
  input  logic       clk40MHz,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_type,
  input  logic [4:0] cmd_arg,
  output logic       cmd_err,
  output logic [4:0] Dout,
  output logic       busy,
  output logic       sh_stop,
  output logic       sh_sweep,
  output logic [4:0] sh_freq_idx,
  output logic       sh_valid
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_N  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_N = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [4:0]       IDLE_C  = 5'(IDLE_CODE);
  localparam logic             AUTO_EN = (AUTO_PRESET != 0);

  tx_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [4:0]       dout_r;
  cmd_t             cur_cmd_r;
  logic             init_done_r;
  logic             err_r;
  logic             sh_stop_r;
  logic             sh_sweep_r;
  logic [4:0]       sh_freq_r;
  logic             sh_valid_r;

  logic             xfer_s;
  logic             legal_s;
  logic             push_s;
  cmd_t             push_data_s;
  logic             pop_s;
  cmd_t             pop_data_s;
  logic             full_s;
  logic             empty_s;
  logic             guard_end_s;

  din_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk40MHz (clk40MHz),
    .rst_n    (rst_n),
    .push     (push_s),
    .push_data(push_data_s),
    .pop      (pop_s),
    .pop_data (pop_data_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // The FIFO is also drained at the last guard cycle so back-to-back gaps stay exactly GUARD_CYCLES
  assign guard_end_s = (state_r == ST_GUARD) && (cnt_r == GUARD_N);
  assign pop_s       = ~empty_s & ((state_r == ST_IDLE) | guard_end_s);
  assign cmd_ready   = init_done_r & (~full_s | pop_s);
  assign xfer_s      = cmd_valid & cmd_ready;
  assign legal_s     = cmd_legal(cmd_type, cmd_arg);
  assign busy        = ~empty_s | (state_r != ST_IDLE);

  assign Dout        = dout_r;
  assign cmd_err     = err_r;
  assign sh_stop     = sh_stop_r;
  assign sh_sweep    = sh_sweep_r;
  assign sh_freq_idx = sh_freq_r;
  assign sh_valid    = sh_valid_r;

  // FIFO write source: the automatic PRESET on the first edge after reset, user commands afterwards
  always_comb begin
    push_s      = 1'b0;
    push_data_s = '0;
    if (!init_done_r) begin
      push_s      = AUTO_EN;
      push_data_s = '{ctype: CMD_PRESET, arg: 5'd0};
    end else begin
      push_s      = xfer_s & legal_s;
      push_data_s = '{ctype: cmd_type, arg: cmd_arg};
    end
  end

  // Post-reset enable and reject pulse
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      init_done_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      init_done_r <= 1'b1;
      err_r       <= xfer_s & ~legal_s;
    end
  end

  // Framing FSM with hold/guard counter and receiver state mirrors
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      dout_r     <= IDLE_C;
      cur_cmd_r  <= '0;
      sh_stop_r  <= 1'b1;
      sh_sweep_r <= 1'b0;
      sh_freq_r  <= 5'd0;
      sh_valid_r <= 1'b0;
    end else if (pop_s) begin
      cur_cmd_r <= pop_data_s;
      dout_r    <= cmd_encode(pop_data_s);
      cnt_r     <= CNT_ONE;
      state_r   <= ST_DRIVE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r  <= '0;
          dout_r <= IDLE_C;
        end
        ST_DRIVE: begin
          if (cnt_r == HOLD_N) begin
            dout_r  <= IDLE_C;
            cnt_r   <= CNT_ONE;
            state_r <= ST_GUARD;
            // The receiver has latched the code by now; mirror its effect
            case (cur_cmd_r.ctype)
              CMD_SETFREQ:   sh_freq_r  <= cur_cmd_r.arg;
              CMD_RUN:       sh_stop_r  <= 1'b0;
              CMD_STOP:      sh_stop_r  <= 1'b1;
              CMD_SWEEP_ON:  sh_sweep_r <= 1'b1;
              CMD_SWEEP_OFF: sh_sweep_r <= 1'b0;
              CMD_PRESET: begin
                sh_freq_r  <= 5'd0;
                sh_stop_r  <= 1'b0;
                sh_sweep_r <= 1'b1;
                sh_valid_r <= 1'b1;
              end
              default: sh_valid_r <= sh_valid_r;
            endcase
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_GUARD: begin
          if (guard_end_s) begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          dout_r  <= IDLE_C;
        end
      endcase
    end
  end

endmodule
